// File: rtl/traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Round-robin phase scheduler for an N-approach signalised intersection.
// Exactly one approach owns the phase at a time. Every handover runs
// GREEN -> YELLOW -> ALL-RED, with each phase length measured by a cycle timer.
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   clear_n      asynchronous active-low reset
//   req          level vehicle-present request, bit i = approach i
//   lights       2-bit light code per approach, bits [2i+1:2i] = approach i
//                (RED=0, YELLOW=1, GREEN=2; 3 is never driven)
//   phase_id     index of the approach owning the phase (GREEN or YELLOW)
//   phase_valid  high while some approach is GREEN or YELLOW
// ----------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic [N_APPR-1:0]   req,
  output logic [2*N_APPR-1:0] lights,
  output logic [2:0]          phase_id,
  output logic                phase_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_ALLRED
  } state_t;

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_GREEN  = 2'd2;

  // Timer values seen on the last cycle of each timed phase. The timer counts
  // cycles already spent in the state, so "timer+1 >= T" becomes "timer >= T-1".
  localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] C_MAX_SAT  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] C_YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_AR_LAST  = CNT_W'(ALLRED_T - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_timer;
  logic [2:0]           r_last_grant;
  logic [2*N_APPR-1:0]  r_lights;
  logic [2:0]           r_phase_id;
  logic                 r_phase_valid;

  logic [2:0] w_winner;
  logic       w_found;
  logic       w_own_req;
  logic       w_others_req;
  logic       w_green_done;

  // Light vector with a single approach driven to 'code' and all others RED.
  function automatic logic [2*N_APPR-1:0] lamp(input logic [2:0] idx,
                                               input logic [1:0] code);
    logic [2*N_APPR-1:0] v;
    v = '0;
    for (int i = 0; i < N_APPR; i++) begin
      if (i == int'(idx)) v[2*i +: 2] = code;
    end
    return v;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_winner     = '0;
    w_found      = 1'b0;
    w_own_req    = 1'b0;
    w_others_req = 1'b0;
    // Round-robin: scan from the approach after the last grant, wrapping;
    // the last grantee itself is reached last, so it wins only when alone.
    for (int k = 1; k <= N_APPR; k++) begin
      for (int i = 0; i < N_APPR; i++) begin
        if (!w_found && req[i] && (i == (int'(r_last_grant) + k) % N_APPR)) begin
          w_found  = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
    for (int i = 0; i < N_APPR; i++) begin
      if (i == int'(r_phase_id)) w_own_req    = req[i];
      else                       w_others_req = w_others_req | req[i];
    end
    // An uncontested green never ends; a contested one ends after MIN_GREEN
    // once its own request drops, or unconditionally after MAX_GREEN.
    w_green_done = w_others_req &&
                   (((r_timer >= C_MIN_LAST) && !w_own_req) || (r_timer >= C_MAX_LAST));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_last_grant  <= 3'(N_APPR - 1);
      r_lights      <= '0;
      r_phase_id    <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state       <= S_GREEN;
            r_timer       <= '0;
            r_last_grant  <= w_winner;
            r_phase_id    <= w_winner;
            r_phase_valid <= 1'b1;
            r_lights      <= lamp(w_winner, L_GREEN);
          end
        end

        S_GREEN: begin
          if (w_green_done) begin
            r_state  <= S_YELLOW;
            r_timer  <= '0;
            r_lights <= lamp(r_phase_id, L_YELLOW);
          end else if (r_timer < C_MAX_SAT) begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_YELLOW: begin
          if (r_timer >= C_YEL_LAST) begin
            r_state       <= S_ALLRED;
            r_timer       <= '0;
            r_lights      <= '0;
            r_phase_valid <= 1'b0;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_ALLRED: begin
          if (r_timer >= C_AR_LAST) begin
            r_timer <= '0;
            if (w_found) begin
              r_state       <= S_GREEN;
              r_last_grant  <= w_winner;
              r_phase_id    <= w_winner;
              r_phase_valid <= 1'b1;
              r_lights      <= lamp(w_winner, L_GREEN);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_timer       <= '0;
          r_lights      <= '0;
          r_phase_valid <= 1'b0;
        end
      endcase
    end
  end

  assign lights      = r_lights;
  assign phase_id    = r_phase_id;
  assign phase_valid = r_phase_valid;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//
// Self-checking bench for traffic_phase_scheduler with default parameters.
// A behavioural model tracks phase kind, owner and phase age from the
// intersection rules and is compared against the DUT every cycle; a vector
// table and hand-written sequences pin down the named corner cases.
// ----------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

  localparam int N  = 4;
  localparam int MG = 4;
  localparam int XG = 10;
  localparam int YT = 3;
  localparam int AT = 2;

  localparam logic [1:0] C_RED = 2'd0;
  localparam logic [1:0] C_YEL = 2'd1;
  localparam logic [1:0] C_GRN = 2'd2;

  // Model phase kinds.
  localparam int K_IDLE = 0;
  localparam int K_GRN  = 1;
  localparam int K_YEL  = 2;
  localparam int K_AR   = 3;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] lights;
  logic [2:0]   phase_id;
  logic         phase_valid;

  int n_tests = 0;
  int n_fail  = 0;

  int m_kind;
  int m_owner;
  int m_last;
  int m_age;
  bit model_on;

  traffic_phase_scheduler #(
    .N_APPR(N), .MIN_GREEN(MG), .MAX_GREEN(XG),
    .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(8)
  ) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .req        (req),
    .lights     (lights),
    .phase_id   (phase_id),
    .phase_valid(phase_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*N-1:0] lamp(input int appr, input logic [1:0] code);
    logic [2*N-1:0] v;
    v = '0;
    v[2*appr +: 2] = code;
    return v;
  endfunction

  // First requesting approach after 'last' in cyclic order, or -1 if none.
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_kind  = K_IDLE;
    m_owner = 0;
    m_last  = N - 1;
    m_age   = 0;
  endfunction

  function automatic void m_grant(input logic [N-1:0] r);
    m_owner = rr_pick(m_last, r);
    m_last  = m_owner;
    m_kind  = K_GRN;
    m_age   = 0;
  endfunction

  // One clock of the intersection rules; m_age = cycles already in the phase.
  function automatic void m_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    case (m_kind)
      K_IDLE: if (r != '0) m_grant(r);
      K_GRN: begin
        others = r;
        others[m_owner] = 1'b0;
        if (others != '0 && ((m_age + 1 >= MG && !r[m_owner]) || m_age + 1 >= XG)) begin
          m_kind = K_YEL;
          m_age  = 0;
        end else m_age++;
      end
      K_YEL: begin
        if (m_age + 1 >= YT) begin m_kind = K_AR; m_age = 0; end
        else m_age++;
      end
      default: begin
        if (m_age + 1 >= AT) begin
          if (r != '0) m_grant(r);
          else begin m_kind = K_IDLE; m_age = 0; end
        end else m_age++;
      end
    endcase
  endfunction

  function automatic logic [2*N-1:0] m_lights();
    if (m_kind == K_GRN) return lamp(m_owner, C_GRN);
    if (m_kind == K_YEL) return lamp(m_owner, C_YEL);
    return '0;
  endfunction

  // Advance one edge, then compare against the model 1 time unit later.
  task automatic tick();
    int lit;
    int bad;
    @(posedge clock);
    m_step(req);
    #1;
    if (model_on) begin
      check("model_lights", 32'(lights), 32'(m_lights()));
      check("model_valid", 32'(phase_valid), 32'(m_kind == K_GRN || m_kind == K_YEL));
      if (m_kind == K_GRN || m_kind == K_YEL)
        check("model_phase_id", 32'(phase_id), 32'(m_owner));
      lit = 0;
      bad = 0;
      for (int i = 0; i < N; i++) begin
        if (lights[2*i +: 2] != C_RED) lit++;
        if (lights[2*i +: 2] == 2'd3) bad++;
      end
      check("one_non_red", 32'(lit <= 1 && bad == 0), 32'd1);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    clear_n = 1'b0;
    #1;
    m_reset();
    check("reset_lights", 32'(lights), 32'd0);
    check("reset_valid", 32'(phase_valid), 32'd0);
    check("reset_phase_id", 32'(phase_id), 32'd0);
    req = '0;
    #2;
    clear_n = 1'b1;
  endtask

  // Counts how many consecutive cycles (including the current one) the
  // outputs hold the given pattern; bounded so a stuck DUT still terminates.
  task automatic count_while(input logic [2*N-1:0] pat, input logic valid, output int n);
    n = 0;
    while (lights == pat && phase_valid == valid && n < 200) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    string          name;
    logic [N-1:0]   req;
    int             cycles;
    logic [2*N-1:0] exp_lights;
    logic           exp_valid;
    logic [2:0]     exp_id;
  } vec_t;

  vec_t tbl[15];
  int n, g;

  initial begin
    tbl[0]  = '{"idle_no_req",     4'b0000,  5, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{"grant_0",         4'b0001,  1, 8'h02, 1'b1, 3'd0};
    tbl[2]  = '{"sole_hold_50",    4'b0001, 50, 8'h02, 1'b1, 3'd0};
    tbl[3]  = '{"sat_contest_yel", 4'b0011,  1, 8'h01, 1'b1, 3'd0};
    tbl[4]  = '{"yel_0_third",     4'b0011,  2, 8'h01, 1'b1, 3'd0};
    tbl[5]  = '{"allred_1",        4'b0011,  1, 8'h00, 1'b0, 3'd0};
    tbl[6]  = '{"allred_2",        4'b0011,  1, 8'h00, 1'b0, 3'd0};
    tbl[7]  = '{"grant_1",         4'b0011,  1, 8'h08, 1'b1, 3'd1};
    tbl[8]  = '{"green_1_tenth",   4'b0011,  9, 8'h08, 1'b1, 3'd1};
    tbl[9]  = '{"max_green_yel",   4'b0011,  1, 8'h04, 1'b1, 3'd1};
    tbl[10] = '{"yel_ignores_req", 4'b0000,  2, 8'h04, 1'b1, 3'd1};
    tbl[11] = '{"allred_1b",       4'b0000,  1, 8'h00, 1'b0, 3'd0};
    tbl[12] = '{"allred_2b",       4'b0000,  1, 8'h00, 1'b0, 3'd0};
    tbl[13] = '{"to_idle",         4'b0000,  1, 8'h00, 1'b0, 3'd0};
    tbl[14] = '{"grant_2",         4'b0100,  1, 8'h20, 1'b1, 3'd2};

    model_on = 1'b1;
    m_reset();
    do_reset();

    // Vector table.
    foreach (tbl[i]) begin
      req = tbl[i].req;
      repeat (tbl[i].cycles) tick();
      check(tbl[i].name, 32'(lights), 32'(tbl[i].exp_lights));
      check({tbl[i].name, "_valid"}, 32'(phase_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check({tbl[i].name, "_id"}, 32'(phase_id), 32'(tbl[i].exp_id));
    end

    // Idle after reset stays all red indefinitely.
    do_reset();
    repeat (30) tick();
    check("idle_long_lights", 32'(lights), 32'd0);

    // Early release: drop req[0] after two green cycles.
    req = 4'b0011;
    tick();
    check("early_grant_0", 32'(lights), 32'(lamp(0, C_GRN)));
    tick();
    req = 4'b0010;
    count_while(lamp(0, C_GRN), 1'b1, n);
    check("early_green_len", 32'(n + 1), 32'(MG));
    count_while(lamp(0, C_YEL), 1'b1, n);
    check("early_yel_len", 32'(n), 32'(YT));
    count_while('0, 1'b0, n);
    check("early_allred_len", 32'(n), 32'(AT));
    check("early_then_1", 32'(lights), 32'(lamp(1, C_GRN)));

    // Rotation with all approaches requesting.
    do_reset();
    req = 4'b1111;
    tick();
    for (g = 0; g < 5; g++) begin
      check("rot_grant", 32'(lights), 32'(lamp(g % N, C_GRN)));
      count_while(lamp(g % N, C_GRN), 1'b1, n);
      check("rot_green_len", 32'(n), 32'(XG));
      count_while(lamp(g % N, C_YEL), 1'b1, n);
      check("rot_yel_len", 32'(n), 32'(YT));
      count_while('0, 1'b0, n);
      check("rot_allred_len", 32'(n), 32'(AT));
    end

    // Reset in the middle of approach 2's yellow.
    do_reset();
    req = 4'b0100;
    tick();
    check("mid_grant_2", 32'(lights), 32'(lamp(2, C_GRN)));
    req = 4'b1100;
    count_while(lamp(2, C_GRN), 1'b1, n);
    tick();
    check("mid_in_yellow", 32'(lights), 32'(lamp(2, C_YEL)));
    do_reset();
    req = 4'b1100;
    tick();
    check("ptr_reset_2", 32'(lights), 32'(lamp(2, C_GRN)));
    check("ptr_reset_2_id", 32'(phase_id), 32'd2);
    do_reset();
    req = 4'b1111;
    tick();
    check("ptr_reset_0", 32'(lights), 32'(lamp(0, C_GRN)));

    // Randomised traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      tick();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
